// File: rtl/my_dmux_stream.sv
// Registered N-way valid/ready stream demultiplexer with unicast and broadcast routing.
// Each channel holds one word, so back-pressure from one consumer only stalls traffic aimed at it.
module my_dmux_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      bcast,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [7:0]                drop_count,
    output logic                      sel_err
);

    logic [CHANNELS-1:0] can_accept;
    logic [CHANNELS-1:0] sel_hot;
    logic [CHANNELS-1:0] load;
    logic                in_range;
    logic                xfer;

    // An all-zero one-hot vector marks an out-of-range select.
    always_comb begin
        sel_hot = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sel_hot[i] = (in_sel == SEL_W'(i));
        end
    end

    assign can_accept = ~out_valid | out_ready;
    assign in_range   = |sel_hot;

    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (bcast) begin
                in_ready = &can_accept;
            end else if (in_range) begin
                in_ready = |(sel_hot & can_accept);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        load = '0;
        if (xfer) begin
            load = bcast ? {CHANNELS{1'b1}} : sel_hot;
        end
    end

    // A load on the same edge as a drain keeps the channel full with the new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= '0;
            out_data   <= '0;
            drop_count <= '0;
            sel_err    <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (load[i]) begin
                    out_data[i*WIDTH +: WIDTH] <= in_data;
                    out_valid[i]               <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
            if (xfer && !bcast && !in_range) begin
                sel_err <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/my_dmux_stream.md
Name: my_dmux_stream

Overview:
- Parametrised, registered N-way demultiplexer for valid/ready streams. It is the sequential successor of the fixed 8-way bit demux.
- Routes each accepted input word to one selected output channel (unicast) or to all channels (broadcast).
- Each channel has a one-entry holding register, so back-pressure is handled per channel.
- Sits between a single producer and up to 2^SEL_W independent consumers.

Parameters:
- WIDTH, 8, data word width in bits (>=1)
- CHANNELS, 8, number of output channels (2..2^SEL_W)
- SEL_W, 3, select field width; CHANNELS <= 2^SEL_W is required, and the bench checks it at elaboration

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- in_data  input  WIDTH  input word
- in_sel  input  SEL_W  destination channel index (unicast)
- bcast  input  1  1 = broadcast the word to all channels; in_sel ignored
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- out_data  output  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- out_valid  output  CHANNELS  channel i holds a word
- out_ready  input  CHANNELS  consumer i takes the word this cycle
- drop_count  output  8  saturating count of words dropped for out-of-range in_sel
- sel_err  output  1  sticky: at least one out-of-range in_sel was accepted

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all channel valid bits = 0, all channel data = 0, drop_count = 0, sel_err = 0.
  - Reset mid-operation discards every held word. No handshake completes in a reset cycle.
  - in_ready is forced to 0 while rst_n=0.
- Per-channel state: one data register and one valid flag. out_valid[i] = valid_i; out_data slice i = data_i, driven directly from registers.
- can_accept_i = !valid_i || out_ready[i] (combinational; a full channel that is being drained this cycle accepts a new word).
- in_ready is combinational from out_ready, bcast and in_sel. There is no registered ready.
  - bcast=0, in_sel < CHANNELS: in_ready = can_accept[in_sel].
  - bcast=0, in_sel >= CHANNELS: in_ready = 1 (the word is sunk).
  - bcast=1: in_ready = AND of can_accept over all channels (all-or-nothing).
- Input transfer: a transfer happens when in_valid && in_ready at the rising edge.
  - Unicast, in range: data_sel <= in_data, valid_sel <= 1.
  - Unicast, out of range: no channel written; drop_count increments, saturating at 255; sel_err <= 1.
  - Broadcast: every channel data <= in_data, valid <= 1.
- Output transfer: out_valid[i] && out_ready[i] at the edge clears valid_i, unless channel i is loaded the same edge. Load wins: valid_i stays 1 and data is replaced.
- A channel not loaded keeps its data register unchanged, including after drain. Only out_valid qualifies out_data.
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: one word per cycle into any channel whose out_ready is held 1. Independent channels never block each other in unicast mode.
- Source rule: in_data, in_sel and bcast must be held stable while in_valid && !in_ready. The block does not check this.
- sel_err and drop_count clear only on reset.
- A stall on one channel blocks the input only while in_sel or bcast targets that channel.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles.
  -> out_valid=0x00, all out_data=0, drop_count=0, sel_err=0, in_ready=0 during reset.
  -> After release, in_ready=1.
- Unicast sweep: out_ready=0xFF; send in_data=0x10+k with in_sel=k for k=0..7 on consecutive cycles.
  -> Each word appears on channel k exactly 1 cycle later, with out_valid one-hot.
  -> in_ready stays 1 throughout.
- Back-pressure: out_ready[3]=0; send 0xA5 then 0x5A to sel=3.
  -> First is accepted. in_ready=0 for the second until out_ready[3]=1.
  -> In that cycle 0xA5 drains and 0x5A loads; out_valid[3] remains 1 with no bubble.
  -> Meanwhile a word to sel=4 is accepted.
- Broadcast all-or-nothing: channel 6 full, out_ready[6]=0; bcast=1, in_data=0x3C.
  -> in_ready=0 and no channel changes.
  -> Raise out_ready[6]: accepted, all 8 channels show 0x3C with out_valid=0xFF next cycle.
- Out-of-range: CHANNELS=5, SEL_W=3; send in_sel=6 for 300 words.
  -> in_ready=1 always, no out_valid asserted, sel_err=1 after first, drop_count saturates at 255.
- Reset mid-stream: channels 0 and 2 hold words with out_ready=0; pulse rst_n=0 for 1 cycle.
  -> out_valid=0x00, counters 0.
  -> The next accepted word is delivered normally.
